// File: rtl/ifetch_pc_unit.sv
// Instruction-fetch stage: holds the PC, fetches words through a ready handshake,
// presents the latched instruction to the decoder and applies next-PC selection on consume.
module ifetch_pc_unit #(
    parameter int unsigned         PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = {PC_WIDTH{1'b0}}
) (
    input  logic                clk,
    input  logic                reset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ready,
    input  logic [31:0]         imem_rdata,
    output logic [31:0]         instr,
    output logic [5:0]          opcode,
    output logic                instr_valid,
    output logic [PC_WIDTH-1:0] pc,
    output logic [PC_WIDTH-1:0] pc_plus4,
    input  logic                stall,
    input  logic                branch_taken,
    input  logic [PC_WIDTH-1:0] branch_target,
    input  logic                jump,
    input  logic [PC_WIDTH-1:0] jump_target,
    output logic [15:0]         issue_count
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        ISSUE = 2'd2
    } state_t;

    localparam logic [PC_WIDTH-1:0] PC_STEP    = {{(PC_WIDTH-3){1'b0}}, 3'b100};
    localparam logic [PC_WIDTH-1:0] ALIGN_MASK = {{(PC_WIDTH-2){1'b1}}, 2'b00};

    state_t              state_r, state_s;
    logic [PC_WIDTH-1:0] pc_r, pc_s;
    logic [PC_WIDTH-1:0] pc_inc_s;
    logic [PC_WIDTH-1:0] next_pc_s;
    logic [31:0]         instr_r, instr_s;
    logic [15:0]         count_r, count_s;
    logic                req_r;
    logic                valid_r;

    assign pc_inc_s = pc_r + PC_STEP;

    // Redirect priority: jump over taken branch over sequential; targets are word aligned.
    always_comb begin
        next_pc_s = pc_inc_s;
        if (jump) begin
            next_pc_s = jump_target & ALIGN_MASK;
        end else if (branch_taken) begin
            next_pc_s = branch_target & ALIGN_MASK;
        end else begin
            next_pc_s = pc_inc_s;
        end
    end

    // Next-state and next-datapath values for the fetch/issue sequence.
    always_comb begin
        state_s = state_r;
        pc_s    = pc_r;
        instr_s = instr_r;
        count_s = count_r;
        case (state_r)
            BOOT: begin
                state_s = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    instr_s = imem_rdata;
                    state_s = ISSUE;
                end else begin
                    state_s = FETCH;
                end
            end
            ISSUE: begin
                if (!stall) begin
                    pc_s    = next_pc_s;
                    count_s = count_r + 16'd1;
                    state_s = FETCH;
                end else begin
                    state_s = ISSUE;
                end
            end
            default: begin
                state_s = BOOT;
            end
        endcase
    end

    // State, datapath and decoded handshake flags; handshake flags track the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= BOOT;
            pc_r    <= RESET_PC;
            instr_r <= 32'h0000_0000;
            count_r <= 16'h0000;
            req_r   <= 1'b0;
            valid_r <= 1'b0;
        end else begin
            state_r <= state_s;
            pc_r    <= pc_s;
            instr_r <= instr_s;
            count_r <= count_s;
            req_r   <= (state_s == FETCH);
            valid_r <= (state_s == ISSUE);
        end
    end

    assign imem_req    = req_r;
    assign imem_addr   = pc_r;
    assign instr       = instr_r;
    assign opcode      = instr_r[31:26];
    assign instr_valid = valid_r;
    assign pc          = pc_r;
    assign pc_plus4    = pc_inc_s;
    assign issue_count = count_r;

endmodule

// File: tb/tb_ifetch_pc_unit.sv
// Directed plus randomized bench for ifetch_pc_unit, checked against a transaction-level
// model of the fetch/consume sequence kept in the bench.
module tb_ifetch_pc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;

    logic        imem_req, instr_valid;
    logic [31:0] imem_addr, instr, pc, pc_plus4;
    logic [5:0]  opcode;
    logic [15:0] issue_count;

    logic        imem_req2, instr_valid2;
    logic [31:0] imem_addr2, instr2, pc2, pc_plus42;
    logic [5:0]  opcode2;
    logic [15:0] issue_count2;

    int checks = 0;
    int errors = 0;

    // Model: phase 0 = waiting to start fetching, 1 = fetching, 2 = holding an instruction.
    int          m_phase;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [15:0] m_count;

    always #5 clk = ~clk;

    ifetch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr), .opcode(opcode),
        .instr_valid(instr_valid), .pc(pc), .pc_plus4(pc_plus4), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .issue_count(issue_count)
    );

    ifetch_pc_unit #(.PC_WIDTH(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset(reset), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata), .instr(instr2), .opcode(opcode2),
        .instr_valid(instr_valid2), .pc(pc2), .pc_plus4(pc_plus42), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target), .jump(jump),
        .jump_target(jump_target), .issue_count(issue_count2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_pc    = 32'h0000_0000;
        m_instr = 32'h0000_0000;
        m_count = 16'h0000;
    endtask

    // One clock edge of the reference behaviour, using the inputs present at the edge.
    task automatic model_edge();
        if (reset) begin
            model_reset();
        end else if (m_phase == 2) begin
            if (!stall) begin
                if (jump)              m_pc = {jump_target[31:2], 2'b00};
                else if (branch_taken) m_pc = {branch_target[31:2], 2'b00};
                else                   m_pc = m_pc + 32'd4;
                m_count = m_count + 16'd1;
                m_phase = 1;
            end
        end else if (m_phase == 1) begin
            if (imem_ready) begin
                m_instr = imem_rdata;
                m_phase = 2;
            end
        end else begin
            m_phase = 1;
        end
    endtask

    task automatic check_all();
        chk("imem_req",    {31'd0, imem_req},    {31'd0, m_phase == 1});
        chk("instr_valid", {31'd0, instr_valid}, {31'd0, m_phase == 2});
        chk("imem_addr",   imem_addr,            m_pc);
        chk("pc",          pc,                   m_pc);
        chk("pc_plus4",    pc_plus4,             m_pc + 32'd4);
        chk("instr",       instr,                m_instr);
        chk("opcode",      {26'd0, opcode},      {26'd0, m_instr[31:26]});
        chk("issue_count", {16'd0, issue_count}, {16'd0, m_count});
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
        branch_taken = 1'b0; branch_target = 32'h0; jump = 1'b0; jump_target = 32'h0;
        model_reset();
        #2;
        check_all();
        chk("reset_opcode", {26'd0, opcode}, 32'd0);

        // Sequential flow with ready tied high, lw returned every time.
        reset = 1'b0; imem_ready = 1'b1; imem_rdata = 32'h8C01_0004;
        step();
        chk("first_addr", imem_addr, 32'h0);
        step();
        chk("lw_opcode", {26'd0, opcode}, {26'd0, 6'b100011});
        chk("lw_valid", {31'd0, instr_valid}, 32'd1);
        chk("wrap_pc", pc2, 32'hFFFF_FFFC);
        chk("wrap_pc_plus4", pc_plus42, 32'h0);
        chk("wrap_valid", {31'd0, instr_valid2}, 32'd1);
        chk("wrap_opcode", {26'd0, opcode2}, {26'd0, 6'b100011});
        step();
        chk("second_addr", imem_addr, 32'h4);
        chk("wrap_second_addr", imem_addr2, 32'h0);
        chk("wrap_req", {31'd0, imem_req2}, 32'd1);
        chk("wrap_count", {16'd0, issue_count2}, 32'd1);
        chk("wrap_instr", instr2, 32'h8C01_0004);
        step(); step(); step(); step();
        chk("count3", {16'd0, issue_count}, 32'd3);

        // Memory not ready for five cycles, then ready captures new data.
        imem_ready = 1'b0; imem_rdata = 32'hFFFF_FFFF;
        for (int i = 0; i < 5; i++) step();
        chk("wait_addr", imem_addr, 32'hC);
        imem_ready = 1'b1; imem_rdata = 32'h1022_0003;
        step();
        chk("late_capture", instr, 32'h1022_0003);

        // Stall with a pending taken branch and a spurious ready.
        stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h40; imem_rdata = 32'hABCD_0123;
        for (int i = 0; i < 3; i++) step();
        chk("stall_pc", pc, 32'hC);
        stall = 1'b0;
        step();
        chk("branch_addr", imem_addr, 32'h40);
        branch_taken = 1'b0;

        // Jump beats branch; jump target low bits are cleared.
        step();
        jump = 1'b1; jump_target = 32'h103; branch_taken = 1'b1; branch_target = 32'h80;
        step();
        chk("jump_addr", imem_addr, 32'h100);
        jump = 1'b0; branch_taken = 1'b0;

        // Asynchronous reset in the middle of a FETCH with ready high.
        imem_rdata = 32'hDEAD_BEEF;
        #2 reset = 1'b1;
        #1 model_reset();
        check_all();
        chk("rst_instr", instr, 32'h0);
        step();
        reset = 1'b0;
        step();
        chk("restart_addr", imem_addr, 32'h0);
        chk("restart_req", {31'd0, imem_req}, 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            imem_ready    = ($urandom_range(0, 3) != 0);
            imem_rdata    = $urandom;
            stall         = ($urandom_range(0, 2) == 0);
            branch_taken  = ($urandom_range(0, 1) == 1);
            branch_target = $urandom;
            jump          = ($urandom_range(0, 3) == 0);
            jump_target   = $urandom;
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
